// File: rtl/accum_arb_pkg.sv
// -----------------------------------------------------------------------------
// accum_arb_pkg
//   Shared types and helpers for the burst-accumulate arbiter.
//   - accum_arb_state_t : top-level FSM state encoding
//   - rr_next()         : round-robin successor index, wrapping at n
// -----------------------------------------------------------------------------
package accum_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_arb_state_t;

  // Index that follows idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/add_accum_core.sv
// -----------------------------------------------------------------------------
// add_accum_core
//   WIDTH-bit accumulator with a WIDTH+1-bit adder and a sticky carry flag.
//   Ports:
//     clk     in   clock, all state on posedge
//     reset   in   synchronous active-high reset (clears acc and ovf)
//     clear   in   synchronous clear of acc and ovf (start of a burst)
//     enable  in   add data into acc this cycle
//     data    in   WIDTH-bit addend
//     acc     out  running sum modulo 2**WIDTH
//     ovf     out  set once any add produced a carry out; held until clear
// -----------------------------------------------------------------------------
module add_accum_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);

  logic [WIDTH:0] sum;

  // The top bit of the widened sum is the carry out of this beat.
  assign sum = {1'b0, acc} + {1'b0, data};

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (enable) begin
      acc <= sum[WIDTH-1:0];
      ovf <= ovf | sum[WIDTH];
    end
  end

endmodule

// File: rtl/accum_burst_arbiter.sv
// -----------------------------------------------------------------------------
// accum_burst_arbiter
//   Shares one add-accumulate datapath between N_REQ requesters. One burst is
//   granted at a time in round-robin order; LEN words from the shared data bus
//   are summed and the sum is returned with a sticky overflow flag and the
//   owning requester ID over a valid/ready result interface.
//   Ports:
//     clk           in   clock, all logic on posedge
//     reset         in   synchronous active-high reset
//     req           in   per-requester burst request (level)
//     len           in   per-requester burst length, slice i = requester i
//     grant         out  one-hot data-bus owner while accumulating
//     data_in       in   shared data bus
//     data_valid    in   data_in valid
//     data_ready    out  accumulator accepting (beat = valid & ready)
//     result        out  burst sum modulo 2**WIDTH
//     result_ovf    out  any beat of the burst carried out
//     result_id     out  requester owning the result
//     result_valid  out  result fields valid
//     result_ready  in   consumer accepts (transfer = valid & ready)
// -----------------------------------------------------------------------------
module accum_burst_arbiter
  import accum_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LEN_W-1:0]   len,
  output logic [N_REQ-1:0]         grant,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     result_ovf,
  output logic [$clog2(N_REQ)-1:0] result_id,
  output logic                     result_valid,
  input  logic                     result_ready
);

  localparam int ID_W = $clog2(N_REQ);

  accum_arb_state_t state, state_next;

  logic [ID_W-1:0]  rr_ptr;     // highest-priority requester for the next pick
  logic [ID_W-1:0]  id_q;       // owner of the current burst / result
  logic [LEN_W-1:0] count_q;    // beats still to accept in ACCUM

  logic [ID_W-1:0]  scan_idx;
  logic [ID_W-1:0]  pick_id;
  logic [LEN_W-1:0] pick_len;
  logic             any_req;

  logic             core_clear;
  logic             core_en;
  logic [WIDTH-1:0] acc;
  logic             acc_ovf;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first set request bit at or above rr_ptr, with wrap.
  // The scan runs from the farthest offset down to offset 0 so the nearest
  // requester is the last to overwrite pick_id.
  // ---------------------------------------------------------------------------
  always_comb begin
    scan_idx = '0;
    pick_id  = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[scan_idx]) pick_id = scan_idx;
    end
  end

  assign any_req  = |req;
  assign pick_len = len[pick_id*LEN_W +: LEN_W];

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    grant        = '0;
    data_ready   = 1'b0;
    result_valid = 1'b0;
    core_clear   = 1'b0;
    core_en      = 1'b0;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          core_clear = 1'b1;
          // A zero-length burst skips accumulation and reports an empty sum.
          state_next = (pick_len == '0) ? DONE : ACCUM;
        end
      end

      ACCUM: begin
        grant[id_q] = 1'b1;
        data_ready  = 1'b1;
        if (data_valid) begin
          core_en = 1'b1;
          if (count_q == LEN_W'(1)) state_next = DONE;
        end
      end

      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Burst bookkeeping: owner, remaining length, round-robin pointer.
  // req/len are only looked at in IDLE, so mid-burst changes have no effect.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      id_q    <= '0;
      count_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            id_q    <= pick_id;
            count_q <= pick_len;
          end
        end
        ACCUM: begin
          if (data_valid) count_q <= count_q - 1'b1;
        end
        DONE: begin
          // Served requester drops to lowest priority once its result leaves.
          if (result_ready) rr_ptr <= ID_W'(rr_next(32'(id_q), N_REQ));
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shared datapath. The accumulator is idle outside ACCUM, so its registers
  // hold the finished sum stable for the whole DONE phase.
  // ---------------------------------------------------------------------------
  add_accum_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (core_clear),
    .enable (core_en),
    .data   (data_in),
    .acc    (acc),
    .ovf    (acc_ovf)
  );

  assign result     = acc;
  assign result_ovf = acc_ovf;
  assign result_id  = id_q;

endmodule
